// File: rtl/cpu_types_pkg.sv
// Shared types for the dual-core memory bus: RAM status, bus controller states,
// arbitration class and core count.
package cpu_types_pkg;

    localparam int CPUS = 2;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IFETCH  = 3'd1,
        WB      = 3'd2,
        SNOOP   = 3'd3,
        FWD     = 3'd4,
        RAMRD   = 3'd5,
        UPGRADE = 3'd6
    } bus_state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_DCACHE = 2'd1,
        CLS_ICACHE = 2'd2
    } req_cls_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational grant: dcache class beats icache class; dcache ties follow
// the round-robin pointer, icache ties always go to core 0.
module bus_rr_arbiter
    import cpu_types_pkg::*;
(
    input  logic [CPUS-1:0] dreq_i,
    input  logic [CPUS-1:0] ireq_i,
    input  logic            rr_ptr_i,
    output logic            gnt_idx_o,
    output req_cls_t        gnt_cls_o
);

    always_comb begin
        gnt_cls_o = CLS_NONE;
        gnt_idx_o = 1'b0;
        if (|dreq_i) begin
            gnt_cls_o = CLS_DCACHE;
            gnt_idx_o = dreq_i[rr_ptr_i] ? rr_ptr_i : ~rr_ptr_i;
        end else if (|ireq_i) begin
            gnt_cls_o = CLS_ICACHE;
            gnt_idx_o = ~ireq_i[0];
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Arbitrates two dcaches and two icaches onto one RAM port, runs the snoop
// handshake and cache-to-cache forwarding; completes as soon as RAM reports ACCESS.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int RAM_LAT = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            iREN,
    input  logic [1:0][31:0]      iaddr,
    output logic [1:0]            iwait,
    output logic [1:0][31:0]      iload,
    input  logic [1:0]            dREN,
    input  logic [1:0]            dWEN,
    input  logic [1:0][31:0]      daddr,
    input  logic [1:0][31:0]      dstore,
    input  logic [1:0]            ccwrite,
    output logic [1:0]            dwait,
    output logic [1:0][31:0]      dload,
    output logic [1:0]            ccwait,
    output logic [1:0]            ccinv,
    output logic [1:0][31:0]      ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);

    if (RAM_LAT < 1) begin : g_bad_ram_lat
        $error("RAM_LAT must be at least 1");
    end

    bus_state_t  state_q, state_d, cur_st;
    logic        rr_q, rr_d;
    logic        req_q, req_d;
    logic [31:0] fwd_q, fwd_d;
    logic        oth, ram_done, gnt_idx;
    req_cls_t    gnt_cls;

    bus_rr_arbiter u_arb (
        .dreq_i    (dREN | dWEN | ccwrite),
        .ireq_i    (iREN),
        .rr_ptr_i  (rr_q),
        .gnt_idx_o (gnt_idx),
        .gnt_cls_o (gnt_cls)
    );

    // Decoding from IDLE while RST is high suppresses any completion pulse in that cycle.
    assign cur_st   = RST ? IDLE : state_q;
    assign oth      = ~req_q;
    assign ram_done = (ramstate == ACCESS);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        req_d       = req_q;
        fwd_d       = fwd_q;
        iwait       = '1;
        iload       = '0;
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (cur_st)
            IDLE: begin
                req_d = gnt_idx;
                if (gnt_cls == CLS_ICACHE) begin
                    state_d = IFETCH;
                end else if (gnt_cls == CLS_DCACHE) begin
                    rr_d = ~gnt_idx;
                    if (dWEN[gnt_idx])      state_d = WB;
                    else if (dREN[gnt_idx]) state_d = SNOOP;
                    else                    state_d = UPGRADE;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[req_q];
                if (ram_done) begin
                    iwait[req_q] = 1'b0;
                    iload[req_q] = ramload;
                    state_d      = IDLE;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[req_q];
                ramstore = dstore[req_q];
                if (ram_done) begin
                    dwait[req_q] = 1'b0;
                    state_d      = IDLE;
                end
            end
            SNOOP: begin
                ccwait[oth]      = 1'b1;
                ccinv[oth]       = ccwrite[req_q];
                ccsnoopaddr[oth] = daddr[req_q];
                if (ccwrite[oth]) begin
                    fwd_d   = dstore[oth];
                    state_d = FWD;
                end else begin
                    state_d = RAMRD;
                end
            end
            FWD: begin
                // Owner's Modified copy goes to RAM and the requester together.
                ramWEN   = 1'b1;
                ramaddr  = daddr[req_q];
                ramstore = fwd_q;
                if (ram_done) begin
                    dwait[req_q] = 1'b0;
                    dload[req_q] = fwd_q;
                    state_d      = IDLE;
                end
            end
            RAMRD: begin
                ramREN  = 1'b1;
                ramaddr = daddr[req_q];
                if (ram_done) begin
                    dwait[req_q] = 1'b0;
                    dload[req_q] = ramload;
                    state_d      = IDLE;
                end
            end
            UPGRADE: begin
                ccwait[oth]      = 1'b1;
                ccinv[oth]       = 1'b1;
                ccsnoopaddr[oth] = daddr[req_q];
                dwait[req_q]     = 1'b0;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            req_q   <= 1'b0;
            fwd_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            req_q   <= req_d;
            fwd_q   <= fwd_d;
        end
    end

endmodule
